// File: rtl/async_operator_buf.sv
// ---------------------------------------------------------------------------
// async_operator_buf
//
// Handshake dataflow node. It joins input_size operand channels, applies the
// arithmetic op selected by the 'op' parameter, and queues results in a
// depth-entry FIFO. Each result is forked to output_size consumers. A token
// leaves the FIFO only after every consumer has acknowledged it.
//
// Parameters:
//   data_width  operand/result width in bits
//   op          "reg","in","out","addi","subi","muli","add","sub","mul"
//   immediate   constant used by the *i ops
//   input_size  operand channels, 1..3 (must be 1 for reg/in/out/*i ops)
//   output_size consumer channels, 1..8
//   depth       FIFO entries, power of two, >= 2
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   req_l  out  [input_size]            request to each upstream producer
//   ack_l  in   [input_size]            one-cycle ack/data-valid from upstream
//   din    in   [data_width*input_size] operands, slice i = channel i
//   req_r  in   [output_size]           request from each consumer
//   ack_r  out  [output_size]           one-cycle ack to each consumer
//   dout   out  [data_width]            FIFO head value
//   level  out  [$clog2(depth)+1]       FIFO occupancy
//
// Optional statistics (macro ASYNC_OPERATOR_BUF_STATS_EN):
//   tokens_out   out [32] number of pops
//   stall_full   out [32] cycles with all operands held but FIFO full, no pop
//   stall_empty  out [32] cycles with any consumer requesting on empty FIFO
//   All three saturate at 2^32-1 and clear on rst.
// ---------------------------------------------------------------------------
module async_operator_buf #(
    parameter int    data_width  = 32,
    parameter string op          = "reg",
    parameter int    immediate   = 0,
    parameter int    input_size  = 1,
    parameter int    output_size = 1,
    parameter int    depth       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [input_size-1:0]            req_l,
    input  logic [input_size-1:0]            ack_l,
    input  logic [data_width*input_size-1:0] din,
    input  logic [output_size-1:0]           req_r,
    output logic [output_size-1:0]           ack_r,
    output logic [data_width-1:0]            dout,
    output logic [$clog2(depth):0]           level
`ifdef ASYNC_OPERATOR_BUF_STATS_EN
    ,
    output logic [31:0]                      tokens_out,
    output logic [31:0]                      stall_full,
    output logic [31:0]                      stall_empty
`endif
);

    localparam int AW = $clog2(depth);
    localparam int LW = AW + 1;
    localparam int PW = 3 * data_width;
    localparam logic [data_width-1:0] IMM = data_width'(immediate);

    genvar gi;

    logic [input_size-1:0]            req_l_q;
    logic [input_size-1:0]            has_q;
    logic [data_width*input_size-1:0] opnd_q;
    logic [output_size-1:0]           ack_r_q;
    logic [output_size-1:0]           sent_q;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // -----------------------------------------------------------------------
    // Operand capture, one independent request/hold slot per input channel.
    // An ack arriving while the slot is already holding data is ignored so
    // a held operand can never be overwritten.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < input_size; gi = gi + 1) begin : g_in
            logic                  req_bit_q;
            logic                  has_bit_q;
            logic [data_width-1:0] opnd_word_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    req_bit_q   <= 1'b0;
                    has_bit_q   <= 1'b0;
                    opnd_word_q <= '0;
                end else if (ack_l[gi] && !has_bit_q) begin
                    opnd_word_q <= din[gi*data_width +: data_width];
                    has_bit_q   <= 1'b1;
                    req_bit_q   <= 1'b0;
                end else if (push) begin
                    has_bit_q   <= 1'b0;
                end else if (!has_bit_q && !req_bit_q) begin
                    req_bit_q   <= 1'b1;
                end
            end

            assign req_l_q[gi]                          = req_bit_q;
            assign has_q[gi]                            = has_bit_q;
            assign opnd_q[gi*data_width +: data_width]  = opnd_word_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Arithmetic. Operands are zero-padded to three channels so every op can
    // be written uniformly; the padding only matters for the 3-input case.
    // -----------------------------------------------------------------------
    logic [PW-1:0]         opnd_pad;
    logic [data_width-1:0] a0;
    logic [data_width-1:0] a1;
    logic [data_width-1:0] a2;
    logic [data_width-1:0] a2_mul;
    logic [data_width-1:0] result;

    assign opnd_pad = PW'(opnd_q);
    assign a0       = opnd_pad[0            +: data_width];
    assign a1       = opnd_pad[data_width   +: data_width];
    assign a2       = opnd_pad[2*data_width +: data_width];
    // A missing third operand must act as 1 for multiplication, not 0.
    assign a2_mul   = (input_size == 3) ? a2 : data_width'(1);

    always_comb begin
        result = a0;
        if (op == "addi") begin
            result = a0 + IMM;
        end else if (op == "subi") begin
            result = a0 - IMM;
        end else if (op == "muli") begin
            result = a0 * IMM;
        end else if (op == "add") begin
            result = a0 + a1 + a2;
        end else if (op == "sub") begin
            result = a0 - a1 - a2;
        end else if (op == "mul") begin
            result = a0 * a1 * a2_mul;
        end
    end

    // -----------------------------------------------------------------------
    // Result FIFO. Storage has no reset so it maps onto block RAM; the head
    // is read into a register each cycle the FIFO is non-empty, which lines
    // the new head up with the first ack pulse issued for it.
    // -----------------------------------------------------------------------
    logic [data_width-1:0] mem [depth];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         rd_ptr_d;
    logic [LW-1:0]         count_q;
    logic [LW-1:0]         count_d;
    logic [data_width-1:0] dout_q;

    assign full  = (count_q == LW'(depth));
    assign empty = (count_q == '0);
    assign pop   = &sent_q;
    // A full FIFO still accepts a result when a slot frees on the same edge.
    assign push  = (&has_q) && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // When empty the last popped value is held.
            if (!empty) begin
                dout_q <= mem[rd_ptr_q];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output fork. Each consumer gets exactly one ack per token; 'sent'
    // remembers who has been served so fast consumers do not wait on slow
    // ones. The pop edge clears every 'sent' bit for the next token.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < output_size; gi = gi + 1) begin : g_out
            logic ack_bit_q;
            logic sent_bit_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ack_bit_q  <= 1'b0;
                    sent_bit_q <= 1'b0;
                end else if (pop) begin
                    ack_bit_q  <= 1'b0;
                    sent_bit_q <= 1'b0;
                end else if (!empty && req_r[gi] && !sent_bit_q && !ack_bit_q) begin
                    ack_bit_q  <= 1'b1;
                    sent_bit_q <= 1'b1;
                end else begin
                    ack_bit_q  <= 1'b0;
                end
            end

            assign ack_r_q[gi] = ack_bit_q;
            assign sent_q[gi]  = sent_bit_q;
        end
    endgenerate

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign dout  = dout_q;
    assign level = count_q;

`ifdef ASYNC_OPERATOR_BUF_STATS_EN
    logic [31:0] tokens_q;
    logic [31:0] stall_full_q;
    logic [31:0] stall_empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tokens_q      <= '0;
            stall_full_q  <= '0;
            stall_empty_q <= '0;
        end else begin
            if (pop && (tokens_q != '1)) begin
                tokens_q <= tokens_q + 32'd1;
            end
            if ((&has_q) && full && !pop && (stall_full_q != '1)) begin
                stall_full_q <= stall_full_q + 32'd1;
            end
            if ((|req_r) && empty && (stall_empty_q != '1)) begin
                stall_empty_q <= stall_empty_q + 32'd1;
            end
        end
    end

    assign tokens_out  = tokens_q;
    assign stall_full  = stall_full_q;
    assign stall_empty = stall_empty_q;
`endif

endmodule

// File: tb/tb_async_operator_buf.sv
module tb_async_operator_buf;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Instance A: addi #2, 1 in / 1 out, depth 4
    logic        a_req_l, a_ack_l, a_req_r, a_ack_r;
    logic [31:0] a_din, a_dout;
    logic [2:0]  a_level;

    // Instance B: add, 2 in / 1 out
    logic [1:0]  b_req_l, b_ack_l;
    logic [63:0] b_din;
    logic        b_req_r, b_ack_r;
    logic [31:0] b_dout;
    logic [2:0]  b_level;

    // Instance C: reg, 1 in / 3 out
    logic        c_req_l, c_ack_l;
    logic [31:0] c_din, c_dout;
    logic [2:0]  c_req_r, c_ack_r;
    logic [2:0]  c_level;

    // Instances D (sub) and E (mul), 8-bit, 2 in, sharing stimulus
    logic [1:0]  de_ack_l, d_req_l, e_req_l;
    logic [15:0] de_din;
    logic        de_req_r, d_ack_r, e_ack_r;
    logic [7:0]  d_dout, e_dout;
    logic [2:0]  d_level, e_level;

    async_operator_buf #(.data_width(32), .op("addi"), .immediate(2), .input_size(1),
                         .output_size(1), .depth(4)) u_a (
        .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
        .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .level(a_level));

    async_operator_buf #(.data_width(32), .op("add"), .immediate(0), .input_size(2),
                         .output_size(1), .depth(4)) u_b (
        .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
        .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .level(b_level));

    async_operator_buf #(.data_width(32), .op("reg"), .immediate(0), .input_size(1),
                         .output_size(3), .depth(4)) u_c (
        .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
        .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout), .level(c_level));

    async_operator_buf #(.data_width(8), .op("sub"), .immediate(0), .input_size(2),
                         .output_size(1), .depth(4)) u_d (
        .clk(clk), .rst(rst), .req_l(d_req_l), .ack_l(de_ack_l), .din(de_din),
        .req_r(de_req_r), .ack_r(d_ack_r), .dout(d_dout), .level(d_level));

    async_operator_buf #(.data_width(8), .op("mul"), .immediate(0), .input_size(2),
                         .output_size(1), .depth(4)) u_e (
        .clk(clk), .rst(rst), .req_l(e_req_l), .ack_l(de_ack_l), .din(de_din),
        .req_r(de_req_r), .ack_r(e_ack_r), .dout(e_dout), .level(e_level));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Producers: wait for the request, then pulse ack for one cycle with data.
    task automatic send_a(input logic [31:0] v);
        int k = 0;
        while (a_req_l !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("a_req_seen", 32'(a_req_l), 32'd1);
        a_din = v; a_ack_l = 1'b1;
        @(negedge clk);
        a_ack_l = 1'b0;
    endtask

    task automatic send_b(input int ch, input logic [31:0] v);
        int k = 0;
        while (b_req_l[ch] !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("b_req_seen", 32'(b_req_l[ch]), 32'd1);
        b_din[ch*32 +: 32] = v; b_ack_l[ch] = 1'b1;
        @(negedge clk);
        b_ack_l[ch] = 1'b0;
    endtask

    task automatic send_c(input logic [31:0] v);
        int k = 0;
        while (c_req_l !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("c_req_seen", 32'(c_req_l), 32'd1);
        c_din = v; c_ack_l = 1'b1;
        @(negedge clk);
        c_ack_l = 1'b0;
    endtask

    task automatic send_de(input logic [7:0] x, input logic [7:0] y);
        int k = 0;
        while ((d_req_l !== 2'b11 || e_req_l !== 2'b11) && k < 100) begin @(negedge clk); k++; end
        check("de_req_seen", 32'({d_req_l, e_req_l}), 32'hF);
        de_din = {y, x}; de_ack_l = 2'b11;
        @(negedge clk);
        de_ack_l = 2'b00;
    endtask

    // Consumers: advance at least one cycle, then wait for the ack pulse.
    task automatic recv_a(input logic [31:0] exp, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (a_ack_r !== 1'b1 && k < 60);
        check({tag, "_ack"}, 32'(a_ack_r), 32'd1);
        check(tag, a_dout, exp);
    endtask

    task automatic recv_b(input logic [31:0] exp, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (b_ack_r !== 1'b1 && k < 60);
        check({tag, "_ack"}, 32'(b_ack_r), 32'd1);
        check(tag, b_dout, exp);
    endtask

    task automatic recv_de(input logic [7:0] exp_d, input logic [7:0] exp_e, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (d_ack_r !== 1'b1 && k < 60);
        check({tag, "_ack"}, 32'({d_ack_r, e_ack_r}), 32'd3);
        check({tag, "_sub"}, 32'(d_dout), 32'(exp_d));
        check({tag, "_mul"}, 32'(e_dout), 32'(exp_e));
    endtask

    int maxlvl;
    int done;
    int bad;
    int cnt [3];

    initial begin
        rst = 1'b1;
        a_ack_l = 0; a_din = 0; a_req_r = 0;
        b_ack_l = 0; b_din = 0; b_req_r = 0;
        c_ack_l = 0; c_din = 0; c_req_r = 0;
        de_ack_l = 0; de_din = 0; de_req_r = 0;

        // Reset state
        @(negedge clk);
        check("rst_req_l", 32'(a_req_l), 32'd0);
        check("rst_ack_r", 32'(c_ack_r), 32'd0);
        check("rst_dout", a_dout, 32'd0);
        check("rst_level", 32'(a_level), 32'd0);
        rst = 1'b0;

        // 1: addi #2, values 0..9, consumer always ready -> 2..11
        a_req_r = 1'b1; maxlvl = 0; done = 0;
        fork
            begin for (int v = 0; v < 10; v++) send_a(32'(v)); end
            begin for (int v = 0; v < 10; v++) recv_a(32'(v + 2), "t1_dout"); done = 1; end
            begin
                for (int k = 0; k < 400 && done == 0; k++) begin
                    @(negedge clk);
                    if (int'(a_level) > maxlvl) maxlvl = int'(a_level);
                end
            end
        join
        check("t1_maxlevel", 32'(maxlvl), 32'd1);

        // 2: add, channel 1 delayed; req_l[0] must stay low while holding 5
        b_req_r = 1'b1;
        send_b(0, 32'd5);
        bad = 0;
        repeat (6) begin @(negedge clk); if (b_req_l[0] !== 1'b0) bad = 1; end
        check("t2_req0_held_low", 32'(bad), 32'd0);
        check("t2_level_waiting", 32'(b_level), 32'd0);
        send_b(1, 32'd10);
        @(negedge clk);
        check("t2_level_after_push", 32'(b_level), 32'd1);
        check("t2_no_early_ack", 32'(b_ack_r), 32'd0);
        recv_b(32'd15, "t2_sum1");
        send_b(0, 32'd7);
        send_b(1, 32'd3);
        recv_b(32'd10, "t2_sum2");

        // 3: stalled consumer, 6 tokens into depth 4, then drain across wrap
        a_req_r = 1'b0;
        for (int v = 20; v < 25; v++) send_a(32'(v));
        bad = 0;
        repeat (4) begin @(negedge clk); if (a_req_l !== 1'b0) bad = 1; end
        check("t3_req_held_low", 32'(bad), 32'd0);
        check("t3_level_full", 32'(a_level), 32'd4);
        fork
            send_a(32'd25);
            begin
                a_req_r = 1'b1;
                for (int i = 0; i < 6; i++) recv_a(32'(22 + i), "t3_drain");
            end
        join
        @(negedge clk);
        check("t3_level_empty", 32'(a_level), 32'd0);

        // 4: 3-way fork, consumer 2 joins late
        c_req_r = 3'b011;
        cnt = '{0, 0, 0};
        fork
            begin send_c(32'd1); send_c(32'd2); end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (k == 8) begin
                        check("t4_cnt0_before", 32'(cnt[0]), 32'd1);
                        check("t4_cnt1_before", 32'(cnt[1]), 32'd1);
                        check("t4_cnt2_before", 32'(cnt[2]), 32'd0);
                        check("t4_level_before", 32'(c_level), 32'd2);
                        c_req_r[2] = 1'b1;
                    end
                    for (int j = 0; j < 3; j++) begin
                        if (c_ack_r[j] === 1'b1) begin
                            check("t4_dout_pulse", c_dout, 32'(cnt[j] + 1));
                            if (j == 2 && cnt[2] == 0)
                                check("t4_no_pop_before_ack2", 32'(c_level), 32'd2);
                            cnt[j]++;
                        end
                    end
                end
            end
        join
        check("t4_cnt0", 32'(cnt[0]), 32'd2);
        check("t4_cnt1", 32'(cnt[1]), 32'd2);
        check("t4_cnt2", 32'(cnt[2]), 32'd2);
        check("t4_level_end", 32'(c_level), 32'd0);

        // 5: 8-bit sub / mul wrap-around
        de_req_r = 1'b1;
        send_de(8'd0, 8'd1);    recv_de(8'hFF, 8'h00, "t5_0_1");
        send_de(8'd16, 8'd16);  recv_de(8'h00, 8'h00, "t5_16_16");
        send_de(8'd200, 8'd3);  recv_de(8'hC5, 8'h58, "t5_200_3");
        @(negedge clk);
        check("t5_levels", 32'({d_level, e_level}), 32'd0);

        // 6: asynchronous reset with 3 tokens queued and an operand held
        a_req_r = 1'b0;
        send_a(32'd30); send_a(32'd31); send_a(32'd32); send_a(32'd33);
        check("t6_level_before", 32'(a_level), 32'd3);
        check("t6_dout_before", a_dout, 32'd32);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req_l", 32'(a_req_l), 32'd0);
        check("t6_rst_ack_r", 32'(a_ack_r), 32'd0);
        check("t6_rst_dout", a_dout, 32'd0);
        check("t6_rst_level", 32'(a_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_req_r = 1'b1;
        bad = 0;
        repeat (20) begin @(negedge clk); if (a_ack_r !== 1'b0) bad = 1; end
        check("t6_no_stale_token", 32'(bad), 32'd0);
        send_a(32'd40);
        recv_a(32'd42, "t6_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
